// File: rtl/issue_scheduler.sv
`default_nettype none
//==============================================================================
// Module      : issue_scheduler
// Description : Round-robin issue arbiter for an ALU pool and a non-pipelined
//               multiplier pool, with a multiplier occupancy counter.
//               Optional macro ISSUE_SCHED_PERF_EN adds saturating perf counters.
// Revision    : 1.0 - initial release
//==============================================================================
module issue_scheduler #(
    parameter int RS_SIZE  = 8,
    parameter int MULT_LAT = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [RS_SIZE-1:0]         rs_req,
    input  logic [RS_SIZE-1:0]         rs_is_mult,
    input  logic                       ex_stall,
    input  logic                       squash,
    output logic [RS_SIZE-1:0]         alu_grant,
    output logic [$clog2(RS_SIZE)-1:0] alu_grant_idx,
    output logic                       alu_grant_valid,
    output logic [RS_SIZE-1:0]         mult_grant,
    output logic [$clog2(RS_SIZE)-1:0] mult_grant_idx,
    output logic                       mult_grant_valid,
    output logic                       mult_busy
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_alu_issues,
    output logic [31:0]                perf_mult_issues,
    output logic [31:0]                perf_stall_cycles
`endif
);

    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] c_busy_load = CW'(MULT_LAT - 1);

    logic [IW-1:0]      r_alu_ptr;
    logic [IW-1:0]      r_mult_ptr;
    logic [CW-1:0]      r_busy_cnt;

    logic [RS_SIZE-1:0] w_alu_pool;
    logic [RS_SIZE-1:0] w_mult_pool;
    logic               w_alu_found;
    logic               w_mult_found;
    logic [IW-1:0]      w_alu_idx;
    logic [IW-1:0]      w_mult_idx;
    logic               w_gate;
    logic               w_alu_valid;
    logic               w_mult_valid;

    assign w_alu_pool  = rs_req & ~rs_is_mult;
    assign w_mult_pool = rs_req & rs_is_mult;
    // Reset is folded into the gate so outputs are zero during reset without a clock.
    assign w_gate      = reset_n & ~ex_stall & ~squash;

    always_comb begin
        w_alu_found  = 1'b0;
        w_alu_idx    = '0;
        w_mult_found = 1'b0;
        w_mult_idx   = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            if (!w_alu_found && w_alu_pool[r_alu_ptr + IW'(k)]) begin
                w_alu_found = 1'b1;
                w_alu_idx   = r_alu_ptr + IW'(k);
            end
            if (!w_mult_found && w_mult_pool[r_mult_ptr + IW'(k)]) begin
                w_mult_found = 1'b1;
                w_mult_idx   = r_mult_ptr + IW'(k);
            end
        end
    end

    assign mult_busy        = (r_busy_cnt != '0);
    assign w_alu_valid      = w_alu_found & w_gate;
    assign w_mult_valid     = w_mult_found & w_gate & ~mult_busy;

    assign alu_grant_valid  = w_alu_valid;
    assign alu_grant_idx    = w_alu_valid ? w_alu_idx : '0;
    assign alu_grant        = w_alu_valid ? (RS_SIZE'(1) << w_alu_idx) : '0;
    assign mult_grant_valid = w_mult_valid;
    assign mult_grant_idx   = w_mult_valid ? w_mult_idx : '0;
    assign mult_grant       = w_mult_valid ? (RS_SIZE'(1) << w_mult_idx) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_ptr  <= '0;
            r_mult_ptr <= '0;
            r_busy_cnt <= '0;
        end else if (squash) begin
            r_alu_ptr  <= '0;
            r_mult_ptr <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_alu_valid) begin
                r_alu_ptr <= w_alu_idx + IW'(1);
            end
            if (w_mult_valid) begin
                r_mult_ptr <= w_mult_idx + IW'(1);
                r_busy_cnt <= c_busy_load;
            end else if (r_busy_cnt != '0) begin
                r_busy_cnt <= r_busy_cnt - CW'(1);
            end
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] r_perf_alu;
    logic [31:0] r_perf_mult;
    logic [31:0] r_perf_stall;

    // Saturating counters; squash intentionally leaves them untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_alu   <= '0;
            r_perf_mult  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_alu_valid && (r_perf_alu != '1)) begin
                r_perf_alu <= r_perf_alu + 32'd1;
            end
            if (w_mult_valid && (r_perf_mult != '1)) begin
                r_perf_mult <= r_perf_mult + 32'd1;
            end
            if (ex_stall && (rs_req != '0) && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_alu_issues   = r_perf_alu;
    assign perf_mult_issues  = r_perf_mult;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
//==============================================================================
// Module      : tb_issue_scheduler
// Description : Self-checking bench for issue_scheduler against a timestamp-based
//               reference model. Perf checks compiled with ISSUE_SCHED_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_issue_scheduler;

    localparam int RS = 8;
    localparam int ML = 4;

    logic          clock;
    logic          reset_n;
    logic [RS-1:0] rs_req;
    logic [RS-1:0] rs_is_mult;
    logic          ex_stall;
    logic          squash;
    logic [RS-1:0] alu_grant;
    logic [2:0]    alu_grant_idx;
    logic          alu_grant_valid;
    logic [RS-1:0] mult_grant;
    logic [2:0]    mult_grant_idx;
    logic          mult_grant_valid;
    logic          mult_busy;
`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0]   perf_alu_issues;
    logic [31:0]   perf_mult_issues;
    logic [31:0]   perf_stall_cycles;
`endif

    issue_scheduler #(.RS_SIZE(RS), .MULT_LAT(ML)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .rs_req           (rs_req),
        .rs_is_mult       (rs_is_mult),
        .ex_stall         (ex_stall),
        .squash           (squash),
        .alu_grant        (alu_grant),
        .alu_grant_idx    (alu_grant_idx),
        .alu_grant_valid  (alu_grant_valid),
        .mult_grant       (mult_grant),
        .mult_grant_idx   (mult_grant_idx),
        .mult_grant_valid (mult_grant_valid),
        .mult_busy        (mult_busy)
`ifdef ISSUE_SCHED_PERF_EN
        ,
        .perf_alu_issues  (perf_alu_issues),
        .perf_mult_issues (perf_mult_issues),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: pointers as plain integers, multiplier availability
    // as the cycle number from which a new mult grant is allowed.
    int m_alu_ptr, m_mult_ptr, m_free_at, m_cycle;
    longint m_perf_alu, m_perf_mult, m_perf_stall;
    logic e_alu_v, e_mult_v, e_busy;
    int   e_alu_idx, e_mult_idx;

    function automatic logic [RS-1:0] onehot(input logic v, input int idx);
        logic [RS-1:0] r;
        r = '0;
        if (v) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_alu_ptr    = 0;
        m_mult_ptr   = 0;
        m_free_at    = 0;
        m_perf_alu   = 0;
        m_perf_mult  = 0;
        m_perf_stall = 0;
    endtask

    task automatic model_eval();
        e_alu_v = 0; e_mult_v = 0; e_alu_idx = 0; e_mult_idx = 0;
        e_busy  = reset_n && (m_cycle < m_free_at);
        if (reset_n && !ex_stall && !squash) begin
            for (int k = 0; k < RS; k++) begin
                int i;
                i = (m_alu_ptr + k) % RS;
                if (!e_alu_v && rs_req[i] && !rs_is_mult[i]) begin
                    e_alu_v = 1; e_alu_idx = i;
                end
            end
            if (!e_busy) begin
                for (int k = 0; k < RS; k++) begin
                    int i;
                    i = (m_mult_ptr + k) % RS;
                    if (!e_mult_v && rs_req[i] && rs_is_mult[i]) begin
                        e_mult_v = 1; e_mult_idx = i;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [RS-1:0] req, input logic [RS-1:0] ism,
                        input logic st, input logic sq);
        rs_req = req; rs_is_mult = ism; ex_stall = st; squash = sq;
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (e_alu_v && m_perf_alu < 64'hFFFF_FFFF) m_perf_alu++;
            if (e_mult_v && m_perf_mult < 64'hFFFF_FFFF) m_perf_mult++;
            if (ex_stall && rs_req != 0 && m_perf_stall < 64'hFFFF_FFFF) m_perf_stall++;
            if (squash) begin
                m_alu_ptr  = 0;
                m_mult_ptr = 0;
                m_free_at  = m_cycle + 1;
            end else begin
                if (e_alu_v) m_alu_ptr = (e_alu_idx + 1) % RS;
                if (e_mult_v) begin
                    m_mult_ptr = (e_mult_idx + 1) % RS;
                    m_free_at  = m_cycle + ML;
                end
            end
        end
        m_cycle++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        rs_req = '1; rs_is_mult = 8'h0F; ex_stall = 0; squash = 0;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            tests++;
            if ({alu_grant, alu_grant_idx, alu_grant_valid, mult_grant,
                 mult_grant_idx, mult_grant_valid, mult_busy} !== '0) begin
                fails++;
                $display("FAIL reset_outputs got alu=%b/%0d/%b mult=%b/%0d/%b busy=%b required all 0",
                         alu_grant, alu_grant_idx, alu_grant_valid, mult_grant,
                         mult_grant_idx, mult_grant_valid, mult_busy);
            end
            @(posedge clock);
        end
        model_reset();
        m_cycle = 0;
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        step(8'b1000_0001, '0, 0, 0);
        tests++;
        if (alu_grant_valid !== 1'b1 || alu_grant_idx !== 3'd0) begin
            fails++;
            $display("FAIL wrap_first got v=%b idx=%0d required v=1 idx=0", alu_grant_valid, alu_grant_idx);
        end
        tick();
        step(8'b1000_0000, '0, 0, 0);
        tests++;
        if (alu_grant_valid !== 1'b1 || alu_grant_idx !== 3'd7 || alu_grant !== 8'h80) begin
            fails++;
            $display("FAIL wrap_seven got v=%b idx=%0d g=%b required v=1 idx=7 g=10000000",
                     alu_grant_valid, alu_grant_idx, alu_grant);
        end
        tick();
        step(8'b1000_0001, '0, 0, 0);
        tests++;
        if (alu_grant_idx !== 3'd0 || alu_grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap_back got v=%b idx=%0d required v=1 idx=0", alu_grant_valid, alu_grant_idx);
        end
        tick();
        step('0, '0, 0, 0);
        tests++;
        if (alu_grant_valid !== 1'b0 || alu_grant !== '0 || alu_grant_idx !== 3'd0) begin
            fails++;
            $display("FAIL no_request got v=%b g=%b idx=%0d required all 0", alu_grant_valid, alu_grant, alu_grant_idx);
        end
        tick();
    endtask

    task automatic test_full_pattern();
        int exp_alu[10] = '{4, 5, 6, 7, 4, 5, 6, 7, 4, 5};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(8'hFF, 8'h0F, 0, 0);
            tests++;
            if (alu_grant_valid !== 1'b1 || alu_grant_idx !== 3'(exp_alu[c])) begin
                fails++;
                $display("FAIL pattern_alu c=%0d got idx=%0d v=%b required idx=%0d v=1",
                         c, alu_grant_idx, alu_grant_valid, exp_alu[c]);
            end
            tests++;
            if (mult_grant_valid !== (c % 4 == 0) ||
                mult_grant !== onehot(c % 4 == 0, c / 4) ||
                mult_busy !== (c % 4 != 0)) begin
                fails++;
                $display("FAIL pattern_mult c=%0d got v=%b g=%b busy=%b required v=%0d g=%b busy=%0d",
                         c, mult_grant_valid, mult_grant, mult_busy, (c % 4 == 0),
                         onehot(c % 4 == 0, c / 4), (c % 4 != 0));
            end
            tick();
        end
    endtask

    task automatic test_stall_expire();
        do_reset();
        step(8'h01, 8'h01, 0, 0);
        tests++;
        if (mult_grant_valid !== 1'b1 || mult_grant_idx !== 3'd0) begin
            fails++;
            $display("FAIL stall_first got v=%b idx=%0d required v=1 idx=0", mult_grant_valid, mult_grant_idx);
        end
        tick();
        for (int c = 1; c <= 5; c++) begin
            step(8'h01, 8'h01, 1, 0);
            tests++;
            if (mult_grant_valid !== 1'b0 || alu_grant_valid !== 1'b0 || mult_busy !== (c < ML)) begin
                fails++;
                $display("FAIL stall_hold c=%0d got mv=%b av=%b busy=%b required mv=0 av=0 busy=%0d",
                         c, mult_grant_valid, alu_grant_valid, mult_busy, (c < ML));
            end
            tick();
        end
        step(8'h01, 8'h01, 0, 0);
        tests++;
        if (mult_grant_valid !== 1'b1 || mult_grant_idx !== 3'd0 || mult_busy !== 1'b0) begin
            fails++;
            $display("FAIL stall_release got v=%b idx=%0d busy=%b required v=1 idx=0 busy=0",
                     mult_grant_valid, mult_grant_idx, mult_busy);
        end
        tick();
    endtask

    task automatic test_squash();
        do_reset();
        step(8'hFF, 8'h0F, 0, 0);
        tick();
        step(8'hFF, 8'h0F, 1, 1);
        tests++;
        if (alu_grant_valid !== 1'b0 || mult_grant_valid !== 1'b0 || alu_grant !== '0 || mult_grant !== '0) begin
            fails++;
            $display("FAIL squash_cycle got av=%b mv=%b required both 0", alu_grant_valid, mult_grant_valid);
        end
        tick();
        step(8'hFF, 8'h0F, 0, 0);
        tests++;
        if (mult_busy !== 1'b0 || mult_grant_valid !== 1'b1 || mult_grant_idx !== 3'd0 ||
            alu_grant_idx !== 3'd4) begin
            fails++;
            $display("FAIL squash_after got busy=%b mv=%b midx=%0d aidx=%0d required busy=0 mv=1 midx=0 aidx=4",
                     mult_busy, mult_grant_valid, mult_grant_idx, alu_grant_idx);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(8'hFF, 8'h0F, 0, 0);
        tick();
        step(8'hFF, 8'h0F, 0, 0);
        tick();
        reset_n = 1'b0;
        #1;
        tests++;
        if ({alu_grant, alu_grant_valid, alu_grant_idx, mult_grant, mult_grant_valid,
             mult_grant_idx, mult_busy} !== '0) begin
            fails++;
            $display("FAIL reset_async got ag=%b mg=%b busy=%b required all 0", alu_grant, mult_grant, mult_busy);
        end
        step(8'hFF, 8'h0F, 0, 0);
        tick();
        tests++;
        if (alu_grant !== '0 || mult_grant !== '0 || mult_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_held got ag=%b mg=%b busy=%b required all 0", alu_grant, mult_grant, mult_busy);
        end
        reset_n = 1'b1;
        step(8'hFF, 8'h0F, 0, 0);
        tests++;
        if (mult_grant_valid !== 1'b1 || mult_grant_idx !== 3'd0 || alu_grant_idx !== 3'd4) begin
            fails++;
            $display("FAIL reset_release got mv=%b midx=%0d aidx=%0d required mv=1 midx=0 aidx=4",
                     mult_grant_valid, mult_grant_idx, alu_grant_idx);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(8'($urandom()) & 8'($urandom()) | 8'($urandom_range(0, 1)),
                 8'($urandom()),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
            tests++;
            if (alu_grant !== onehot(e_alu_v, e_alu_idx) || alu_grant_valid !== e_alu_v ||
                alu_grant_idx !== 3'(e_alu_idx)) begin
                fails++;
                $display("FAIL rand_alu c=%0d got g=%b v=%b idx=%0d required g=%b v=%b idx=%0d",
                         c, alu_grant, alu_grant_valid, alu_grant_idx,
                         onehot(e_alu_v, e_alu_idx), e_alu_v, e_alu_idx);
            end
            tests++;
            if (mult_grant !== onehot(e_mult_v, e_mult_idx) || mult_grant_valid !== e_mult_v ||
                mult_grant_idx !== 3'(e_mult_idx) || mult_busy !== e_busy) begin
                fails++;
                $display("FAIL rand_mult c=%0d got g=%b v=%b idx=%0d busy=%b required g=%b v=%b idx=%0d busy=%b",
                         c, mult_grant, mult_grant_valid, mult_grant_idx, mult_busy,
                         onehot(e_mult_v, e_mult_idx), e_mult_v, e_mult_idx, e_busy);
            end
            tests++;
            if ((alu_grant & mult_grant) !== '0) begin
                fails++;
                $display("FAIL rand_overlap c=%0d got overlap=%b required 0", c, alu_grant & mult_grant);
            end
            tick();
        end
`ifdef ISSUE_SCHED_PERF_EN
        tests++;
        if (perf_alu_issues !== 32'(m_perf_alu) || perf_mult_issues !== 32'(m_perf_mult) ||
            perf_stall_cycles !== 32'(m_perf_stall)) begin
            fails++;
            $display("FAIL rand_perf got %0d/%0d/%0d required %0d/%0d/%0d", perf_alu_issues,
                     perf_mult_issues, perf_stall_cycles, m_perf_alu, m_perf_mult, m_perf_stall);
        end
`endif
    endtask

`ifdef ISSUE_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(8'h01, 8'h00, 0, 0);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            step(8'h01, 8'h00, 1, 0);
            tick();
        end
        step(8'h00, 8'h00, 1, 0);
        tick();
        step(8'h00, 8'h00, 0, 1);
        tick();
        tests++;
        if (perf_alu_issues !== 32'd10 || perf_stall_cycles !== 32'd3 || perf_mult_issues !== 32'd0) begin
            fails++;
            $display("FAIL perf_counts got alu=%0d stall=%0d mult=%0d required 10/3/0",
                     perf_alu_issues, perf_stall_cycles, perf_mult_issues);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; rs_req = '0; rs_is_mult = '0; ex_stall = 0; squash = 0;
        m_cycle = 0;
        model_reset();
        test_reset();
        test_wrap();
        test_full_pattern();
        test_stall_expire();
        test_squash();
        test_reset_mid();
        test_random();
`ifdef ISSUE_SCHED_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter RS_SIZE, default 8: number of reservation-station entries arbitrated; power of two, >=2.
REQ-002 Parameter MULT_LAT, default 4: multiplier occupancy in cycles; >=1; multiplier is non-pipelined.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rs_req  input  RS_SIZE  bit i = entry i valid with operands ready.
REQ-006 rs_is_mult  input  RS_SIZE  bit i = entry i needs the multiplier; else the ALU.
REQ-007 ex_stall  input  1  EX cannot accept an issue this cycle.
REQ-008 squash  input  1  pipeline flush.
REQ-009 alu_grant  output  RS_SIZE  one-hot-or-zero ALU issue grant, same cycle as request.
REQ-010 alu_grant_idx  output  $clog2(RS_SIZE)  index of ALU grant; 0 when none.
REQ-011 alu_grant_valid  output  1  OR of alu_grant.
REQ-012 mult_grant / mult_grant_idx / mult_grant_valid  output  RS_SIZE / $clog2(RS_SIZE) / 1  same meaning for the multiplier.
REQ-013 mult_busy  output  1  multiplier occupied; no mult grant possible.

Function
REQ-014 Grants are combinational from inputs and registered state; zero-cycle latency from rs_req to grant.
REQ-015 At most one ALU grant and one multiplier grant per cycle; an entry never receives both.
REQ-016 ALU pool = rs_req & ~rs_is_mult; mult pool = rs_req & rs_is_mult.
REQ-017 Each pool is round-robin: search starts at its pointer (alu_ptr / mult_ptr), ascending, wrapping RS_SIZE-1 -> 0; first requester wins.
REQ-018 On a grant at index i, that pool's pointer becomes (i+1) mod RS_SIZE next cycle; with no grant it holds.
REQ-019 Mult grant requires mult_busy=0.
REQ-020 Busy counter: on a mult grant load MULT_LAT-1; else decrement when nonzero; mult_busy = (counter != 0); MULT_LAT=1 never asserts busy.
REQ-021 Mult grant at cycle t -> earliest next mult grant at t+MULT_LAT.
REQ-022 ex_stall=1: all grants 0, pointers hold, busy counter keeps decrementing.
REQ-023 squash=1: all grants 0; next cycle both pointers=0 and busy counter=0.
REQ-024 squash and ex_stall together: squash behaviour applies.
REQ-025 rs_req=0: grants 0, pointers hold.

Reset
REQ-026 reset_n low: alu_ptr=0, mult_ptr=0, busy counter=0, mult_busy=0, every grant/idx/valid output 0 irrespective of inputs, perf counters 0.
REQ-027 Reset asserted mid-multiply aborts occupancy; first cycle after release accepts a mult grant.

Configuration
REQ-028 Macro ISSUE_SCHED_PERF_EN: when defined, adds outputs perf_alu_issues, perf_mult_issues, perf_stall_cycles (32 bits each).
REQ-029 With ISSUE_SCHED_PERF_EN: counters increment per ALU grant, per mult grant, and per cycle with ex_stall=1 and rs_req!=0 respectively; saturate at 2^32-1; squash does not clear them.
REQ-030 Without ISSUE_SCHED_PERF_EN: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-031 After reset, rs_req=8'b1000_0001, rs_is_mult=0 -> cycle 1 grants idx 0; entry 0 dropped -> cycle 2 grants idx 7; alu_ptr then wraps to 0.
REQ-032 rs_req=8'hFF, rs_is_mult=8'h0F, held -> ALU grants idx 4,5,6,7,4...; mult grants idx 0 at t, 1 at t+4, 2 at t+8; mult_busy high t+1..t+3.
REQ-033 Mult grant at t, ex_stall high t+1..t+5 -> counter still expires; first cycle after stall drops grants a mult immediately.
REQ-034 Mult grant at t, squash at t+1 -> no grants at t+1; at t+2 mult_busy=0, pointers 0, lowest mult requester granted.
REQ-035 reset_n dropped mid-operation with rs_req=8'hFF -> all outputs 0 during reset, independent of clock; after release idx 0 granted first.
REQ-036 With ISSUE_SCHED_PERF_EN, 10 ALU grants and 3 stall cycles with pending requests -> perf_alu_issues=10, perf_stall_cycles=3; preloaded 32'hFFFF_FFFF stays saturated.
